// File: rtl/go_pkg.sv
`default_nettype none
// ============================================================================
// go_pkg : shared Go board types, move encoding and arbiter state encoding.
// Rev 1.0
// ============================================================================
package go_pkg;

  localparam int         BOARD_N   = 9;
  localparam logic [3:0] BOARD_LIM = 4'(BOARD_N);
  localparam logic [7:0] PASS_CODE = 8'hFF;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    COMMIT = 3'd2,
    SEND   = 3'd3,
    OVER   = 3'd4
  } arb_state_t;

  typedef logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_t;

  function automatic logic [3:0] move_row(input logic [7:0] m);
    return m[7:4];
  endfunction

  function automatic logic [3:0] move_col(input logic [7:0] m);
    return m[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_check.sv
`default_nettype none
// ============================================================================
// move_check : combinational classifier of a move against the current board.
// Rev 1.0
// ============================================================================
module move_check
  import go_pkg::*;
(
  input  logic [7:0] move_i,
  input  board_t     board_i,
  output logic       is_pass_o,
  output logic       is_place_o,
  output logic       is_illegal_o
);

  logic [3:0] w_row;
  logic [3:0] w_col;
  logic [1:0] w_cell;
  logic       w_in_range;

  assign w_row      = move_row(move_i);
  assign w_col      = move_col(move_i);
  assign w_in_range = (w_row < BOARD_LIM) && (w_col < BOARD_LIM);

  // Mux the addressed cell without indexing past the array on off-board moves.
  always_comb begin
    w_cell = EMPTY;
    for (int r = 0; r < BOARD_N; r++) begin
      for (int c = 0; c < BOARD_N; c++) begin
        if ((4'(r) == w_row) && (4'(c) == w_col)) begin
          w_cell = board_i[r][c];
        end
      end
    end
  end

  assign is_pass_o    = (move_i == PASS_CODE);
  assign is_place_o   = !is_pass_o && w_in_range && (w_cell == EMPTY);
  assign is_illegal_o = !is_pass_o && !is_place_o;

endmodule
`default_nettype wire

// File: rtl/move_arbiter.sv
`default_nettype none
// ============================================================================
// move_arbiter : owns the board, alternates local/remote turns, validates,
//                commits and forwards local moves; ends game on passes.
// Rev 1.0
// ============================================================================
module move_arbiter
  import go_pkg::*;
#(
  parameter int PASS_LIMIT = 2
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [1:0] local_color,
  input  logic       move_ready,
  input  logic [7:0] move_out,
  input  logic       rx_valid,
  input  logic [7:0] rx_move,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_move,
  input  logic       tx_ready,
  output board_t     board,
  output logic       my_turn,
  output logic       illegal,
  output logic       illegal_remote,
  output logic       game_over,
  output logic [7:0] move_count
);

  arb_state_t state_q, state_d;
  board_t     board_q, board_d;
  logic [1:0] to_move_q, to_move_d;
  logic [7:0] move_q, move_d;
  logic       remote_q, remote_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_move_q, tx_move_d;
  logic       illegal_q, illegal_d;
  logic       illegal_remote_q, illegal_remote_d;
  logic       game_over_q, game_over_d;
  logic [7:0] move_count_q, move_count_d;
  logic [3:0] pass_cnt_q, pass_cnt_d;

  logic       w_is_pass, w_is_place, w_is_illegal;
  logic       w_local_turn;
  logic       w_game_end;

  move_check u_move_check (
    .move_i       (move_q),
    .board_i      (board_q),
    .is_pass_o    (w_is_pass),
    .is_place_o   (w_is_place),
    .is_illegal_o (w_is_illegal)
  );

  assign w_local_turn = (to_move_q == local_color);
  assign my_turn      = (state_q == IDLE) &&  w_local_turn && !game_over_q;
  assign rx_ready     = (state_q == IDLE) && !w_local_turn && !game_over_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q          <= IDLE;
      board_q          <= '0;
      to_move_q        <= BLACK;
      move_q           <= '0;
      remote_q         <= 1'b0;
      tx_valid_q       <= 1'b0;
      tx_move_q        <= '0;
      illegal_q        <= 1'b0;
      illegal_remote_q <= 1'b0;
      game_over_q      <= 1'b0;
      move_count_q     <= '0;
      pass_cnt_q       <= '0;
    end else begin
      state_q          <= state_d;
      board_q          <= board_d;
      to_move_q        <= to_move_d;
      move_q           <= move_d;
      remote_q         <= remote_d;
      tx_valid_q       <= tx_valid_d;
      tx_move_q        <= tx_move_d;
      illegal_q        <= illegal_d;
      illegal_remote_q <= illegal_remote_d;
      game_over_q      <= game_over_d;
      move_count_q     <= move_count_d;
      pass_cnt_q       <= pass_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    board_d          = board_q;
    to_move_d        = to_move_q;
    move_d           = move_q;
    remote_d         = remote_q;
    tx_valid_d       = tx_valid_q;
    tx_move_d        = tx_move_q;
    illegal_d        = 1'b0;
    illegal_remote_d = 1'b0;
    game_over_d      = game_over_q;
    move_count_d     = move_count_q;
    pass_cnt_d       = pass_cnt_q;
    w_game_end       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (my_turn && move_ready) begin
          move_d   = move_out;
          remote_d = 1'b0;
          state_d  = CHECK;
        end else if (rx_ready && rx_valid) begin
          move_d   = rx_move;
          remote_d = 1'b1;
          state_d  = CHECK;
        end
      end

      CHECK: begin
        if (w_is_illegal) begin
          illegal_d        = 1'b1;
          illegal_remote_d = remote_q;
          state_d          = IDLE;
        end else begin
          state_d = COMMIT;
        end
      end

      // Board is untouched since CHECK, so the classifier is still valid here.
      COMMIT: begin
        if (w_is_pass) begin
          pass_cnt_d = pass_cnt_q + 4'd1;
        end else if (w_is_place) begin
          pass_cnt_d = '0;
          for (int r = 0; r < BOARD_N; r++) begin
            for (int c = 0; c < BOARD_N; c++) begin
              if ((4'(r) == move_row(move_q)) && (4'(c) == move_col(move_q))) begin
                board_d[r][c] = to_move_q;
              end
            end
          end
        end
        move_count_d = (move_count_q == 8'hFF) ? move_count_q : move_count_q + 8'd1;
        to_move_d    = (to_move_q == BLACK) ? WHITE : BLACK;
        w_game_end   = (pass_cnt_d >= 4'(PASS_LIMIT));
        if (w_game_end) begin
          game_over_d = 1'b1;
        end
        if (!remote_q) begin
          tx_move_d  = move_q;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end else begin
          state_d = w_game_end ? OVER : IDLE;
        end
      end

      SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = game_over_q ? OVER : IDLE;
        end
      end

      OVER: begin
        state_d = OVER;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign board          = board_q;
  assign tx_valid       = tx_valid_q;
  assign tx_move        = tx_move_q;
  assign illegal        = illegal_q;
  assign illegal_remote = illegal_remote_q;
  assign game_over      = game_over_q;
  assign move_count     = move_count_q;

endmodule
`default_nettype wire

// File: tb/tb_move_arbiter.sv
`default_nettype none
// ============================================================================
// tb_move_arbiter : scoreboard bench for move_arbiter turn/commit/send flow.
// Rev 1.0
// ============================================================================
module tb_move_arbiter;

  logic                   clk_in = 1'b0;
  logic                   reset;
  logic [1:0]             local_color;
  logic                   move_ready;
  logic [7:0]             move_out;
  logic                   rx_valid;
  logic [7:0]             rx_move;
  logic                   rx_ready;
  logic                   tx_valid;
  logic [7:0]             tx_move;
  logic                   tx_ready;
  logic [8:0][8:0][1:0]   board;
  logic                   my_turn;
  logic                   illegal;
  logic                   illegal_remote;
  logic                   game_over;
  logic [7:0]             move_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_tx[$];
  logic       exp_ill[$];

  always #5 clk_in = ~clk_in;

  move_arbiter #(.PASS_LIMIT(2)) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .local_color    (local_color),
    .move_ready     (move_ready),
    .move_out       (move_out),
    .rx_valid       (rx_valid),
    .rx_move        (rx_move),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_move        (tx_move),
    .tx_ready       (tx_ready),
    .board          (board),
    .my_turn        (my_turn),
    .illegal        (illegal),
    .illegal_remote (illegal_remote),
    .game_over      (game_over),
    .move_count     (move_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and score any illegal pulse seen there.
  task automatic tick();
    @(negedge clk_in);
    if (!reset && illegal) begin
      if (exp_ill.size() == 0) begin
        check_eq("illegal_unexpected", 32'(illegal_remote), 32'hDEAD);
      end else begin
        check_eq("illegal_remote", 32'(illegal_remote), 32'(exp_ill.pop_front()));
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    move_ready = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    move_out = '0; rx_move = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic local_move(input logic [7:0] m);
    tick();
    move_ready = 1'b1; move_out = m;
    tick();
    move_ready = 1'b0;
  endtask

  task automatic remote_move(input logic [7:0] m);
    int k;
    k = 0;
    while (!rx_ready && k < 20) begin tick(); k++; end
    if (!rx_ready) check_eq("rx_ready_timeout", 32'(rx_ready), 32'd1);
    rx_valid = 1'b1; rx_move = m;
    tick();
    rx_valid = 1'b0;
  endtask

  // Complete one TX handshake and score the transmitted move.
  task automatic ack();
    int k;
    k = 0;
    while (!tx_valid && k < 20) begin tick(); k++; end
    if (!tx_valid) begin
      check_eq("tx_valid_timeout", 32'(tx_valid), 32'd1);
    end else begin
      tx_ready = 1'b1;
      if (exp_tx.size() == 0) check_eq("tx_unexpected", 32'(tx_move), 32'hDEAD);
      else                    check_eq("tx_move", 32'(tx_move), 32'(exp_tx.pop_front()));
      tick();
      tx_ready = 1'b0;
    end
  endtask

  initial begin
    local_color = 2'b01;
    do_reset();
    check_eq("rst_board", 32'(board != '0), 32'd0);
    check_eq("rst_count", 32'(move_count), 32'd0);
    check_eq("rst_my_turn", 32'(my_turn), 32'd1);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_game_over", 32'(game_over), 32'd0);

    // Local place at 4,4
    exp_tx.push_back(8'h44);
    local_move(8'h44);
    check_eq("my_turn_t1", 32'(my_turn), 32'd0);
    tick(); tick();
    check_eq("b44_black", 32'(board[4][4]), 32'd1);
    check_eq("tx_valid_t3", 32'(tx_valid), 32'd1);
    tick();
    check_eq("tx_hold_valid", 32'(tx_valid), 32'd1);
    check_eq("tx_hold_move", 32'(tx_move), 32'h44);
    ack();
    check_eq("post_send_my_turn", 32'(my_turn), 32'd0);
    check_eq("post_send_rx_ready", 32'(rx_ready), 32'd1);
    check_eq("post_send_tx_valid", 32'(tx_valid), 32'd0);

    // Remote onto occupied cell, then a legal remote place
    exp_ill.push_back(1'b1);
    remote_move(8'h44);
    tick(); tick();
    check_eq("ill_count", 32'(move_count), 32'd1);
    check_eq("ill_rx_ready", 32'(rx_ready), 32'd1);
    remote_move(8'h45);
    tick(); tick();
    check_eq("b45_white", 32'(board[4][5]), 32'd2);
    check_eq("count_2", 32'(move_count), 32'd2);
    check_eq("my_turn_back", 32'(my_turn), 32'd1);

    // Local off-board move
    exp_ill.push_back(1'b0);
    local_move(8'h9A);
    tick(); tick();
    check_eq("ill_local_turn", 32'(my_turn), 32'd1);
    check_eq("ill_local_tx", 32'(tx_valid), 32'd0);
    check_eq("ill_local_count", 32'(move_count), 32'd2);

    // Simultaneous local and rx on local turn: only local taken
    exp_tx.push_back(8'h00);
    rx_valid = 1'b1; rx_move = 8'h01;
    local_move(8'h00);
    rx_valid = 1'b0;
    tick(); tick();
    check_eq("both_b00", 32'(board[0][0]), 32'd1);
    check_eq("both_b01", 32'(board[0][1]), 32'd0);
    ack();

    // Pass, remote illegal, remote pass -> game over
    do_reset();
    exp_tx.push_back(8'hFF);
    local_move(8'hFF);
    ack();
    exp_ill.push_back(1'b1);
    remote_move(8'h3C);
    tick(); tick();
    remote_move(8'hFF);
    tick(); tick();
    check_eq("go_flag", 32'(game_over), 32'd1);
    check_eq("go_my_turn", 32'(my_turn), 32'd0);
    check_eq("go_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("go_count", 32'(move_count), 32'd2);
    local_move(8'h00);
    tick(); tick(); tick();
    check_eq("go_board_idle", 32'(board != '0), 32'd0);
    check_eq("go_count_hold", 32'(move_count), 32'd2);
    check_eq("go_no_tx", 32'(tx_valid), 32'd0);

    // Pass, place, pass -> counter cleared, no game over
    do_reset();
    exp_tx.push_back(8'hFF);
    local_move(8'hFF);
    ack();
    remote_move(8'h00);
    tick(); tick();
    check_eq("ppp_b00_white", 32'(board[0][0]), 32'd2);
    exp_tx.push_back(8'hFF);
    local_move(8'hFF);
    ack();
    check_eq("ppp_game_over", 32'(game_over), 32'd0);
    check_eq("ppp_count", 32'(move_count), 32'd3);
    check_eq("ppp_rx_ready", 32'(rx_ready), 32'd1);

    // Reset while waiting in SEND
    do_reset();
    local_move(8'h12);
    tick(); tick();
    check_eq("send_pre_valid", 32'(tx_valid), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("rst_send_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_send_board", 32'(board != '0), 32'd0);
    check_eq("rst_send_count", 32'(move_count), 32'd0);
    check_eq("rst_send_my_turn", 32'(my_turn), 32'd1);
    reset = 1'b0;
    tick();

    check_eq("sb_tx_drain", 32'(exp_tx.size()), 32'd0);
    check_eq("sb_ill_drain", 32'(exp_ill.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
